bus_arb4: RTL
=============

# bus_arb4

Round-robin arbiter that shares one 4:1 tristate bus (the mux41/bufif1 datapath) between four requesters. It grants the bus to exactly one requester at a time and drives the one-hot enables for the four bufif1 drivers. It inserts a one-cycle turnaround between owners so two drivers never overlap, and it forcibly ends any tenure that exceeds MAXHOLD cycles.

## Interface
- MAXHOLD, 8: maximum tenure in cycles; legal range 1..255.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  4  request lines; req[i]=1 means requester i wants the bus. Level-sensitive and held for the whole tenure.
- gnt  out  4  one-hot grant, all-zero when no owner; gnt[i] enables bufif1 driver i.
- sel  out  2  encoded index of the current or most recent owner.
- busy  out  1  high while any gnt bit is high.
- expire  out  1  one-cycle pulse in the first TURN cycle after a forced release.

## Operation
- States:
  - IDLE: no owner.
  - OWN: gnt[sel]=1.
  - TURN: all gnt=0, exactly one cycle.
- ptr (2 bits) is the highest-priority index. Priority order is ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- IDLE → OWN when any req bit is high.
  - sel ← the winning index.
  - cnt ← 0.
  - Otherwise stay in IDLE.
- OWN, per cycle:
  - If req[sel]=0, release normally → TURN.
  - Else if cnt==MAXHOLD-1, force release → TURN and set expire=1 for that TURN cycle.
  - Else cnt ← cnt+1.
- On every release, ptr ← sel+1 (mod 4).
- TURN arbitrates with the updated ptr:
  - Any req high → OWN, loading the new sel and cnt=0.
  - Otherwise → IDLE.
- The req bits of non-owners are ignored during OWN.
- An owner that drops req and re-raises it during TURN competes at the lowest priority.
- A forced-off owner that still holds req also competes at the lowest priority. If it is the sole requester, it is regranted after the one TURN cycle.
- cnt is 8 bits, compares against MAXHOLD-1, and never wraps.
- Invariant: gnt is zero or one-hot at all times. gnt is never nonzero in consecutive cycles for two different indices.

## Timing
- Reset values: state=IDLE, gnt=0000, sel=00, busy=0, expire=0, ptr=00, cnt=0.
- Reset is asynchronous: gnt drops to 0000 immediately, even mid-tenure. The first grant after reset is released follows the IDLE rules.
- Grant latency from IDLE: req sampled high at edge k → gnt valid after edge k.
  - Combinationally, req set before edge k gives gnt after edge k, i.e. one-cycle latency from assertion.
- Release: req[sel] sampled low at edge n → gnt=0000 after edge n. The next grant appears after edge n+1 at the earliest.
- Forced release: gnt stays high for exactly MAXHOLD cycles. With MAXHOLD=1, tenure is one cycle.
- Back-to-back owners: grant, then exactly one all-zero cycle, then the next grant.
- busy is registered alongside gnt; expire is registered.
- No combinational path from req to any output.

## Structure
- Package bus_arb_pkg holds:
  - state encoding localparams: S_IDLE=2'd0, S_OWN=2'd1, S_TURN=2'd2;
  - NREQ=4;
  - the cnt width (8).
- Sub-module rr_pick4 (combinational):
  - inputs req[3:0] and ptr[1:0];
  - outputs valid and idx[1:0];
  - instantiated once and shared by IDLE and TURN.
- gnt is produced by the existing dec24 decoder. Its select input is the registered sel, and its enable input is the registered flag (state==S_OWN).

## Test plan
- Reset: assert reset mid-tenure with req=0010 held → gnt=0000, busy=0, sel=00 immediately. After release, the grant returns to index 1 one cycle later.
- Single requester: req=0100 for 3 cycles, then 0000 → gnt=0100 for 3 cycles, sel=2, then gnt=0000 and state IDLE. expire never pulses.
- Round-robin: req=1111 held, MAXHOLD=2 → gnt sequence 0001,0001,0000,0010,0010,0000,0100,0100,0000,1000,1000,0000,0001. expire pulses in each 0000 cycle.
- Fairness after release: ptr=0, owner 0 releases while req=1001 → next grant is 1000, then 0001 after index 3 releases.
- Sole forced owner: MAXHOLD=4, req=0001 held for 12 cycles → grant pattern is 4 high, 1 low, repeating.
- Invariant check on random req over 10k cycles: gnt is always zero or one-hot, every owner change has a one-cycle gap, and no tenure exceeds MAXHOLD.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the four-way round-robin bus arbiter.
// Contents: requester count, hold-counter width, and the arbiter state encoding.
package bus_arb_pkg;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_TURN = 2'd2
    } state_e;

endpackage

// File: rtl/bus_arb4_if.sv
// Handshake bundle between the arbiter and the four requesters.
//   req    : per-requester bus request (level, held for the whole tenure)
//   gnt    : one-hot bufif1 enables, zero when the bus is free
//   sel    : index of the current or most recent owner
//   busy   : a grant is active
//   expire : pulse in the turnaround cycle after a forced release
// master : arbiter side, slave : requester side.
interface bus_arb4_if;
    import bus_arb_pkg::*;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [1:0]      sel;
    logic            busy;
    logic            expire;

    modport master (input req, output gnt, output sel, output busy, output expire);
    modport slave  (output req, input gnt, input sel, input busy, input expire);

endinterface

// File: rtl/dec24.sv
// 2-to-4 decoder with enable, drives the bufif1 enables of the shared bus.
//   sel : index to assert
//   en  : when low all outputs are zero
//   y   : one-hot (or zero) output
module dec24 (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : highest-priority index; priority runs ptr, ptr+1, ptr+2, ptr+3 (mod 4)
//   valid : at least one request present
//   idx   : winning index (equals ptr when nothing is requested)
module rr_pick4
    import bus_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       valid,
    output logic [1:0] idx
);

    logic [7:0] dbl;
    logic [3:0] rot;
    logic [1:0] off;

    always_comb begin
        // Rotate so bit 0 is the ptr requester, then take the lowest set bit.
        dbl = {req, req} >> ptr;
        rot = dbl[3:0];
        off = 2'd0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            if (rot[k-1]) begin
                off = 2'(k - 1);
            end
        end
        valid = |req;
        idx   = ptr + off;
    end

endmodule

// File: rtl/bus_arb4.sv
// Round-robin arbiter for a 4:1 tristate bus.
// Grants one requester at a time, inserts a one-cycle all-off turnaround
// between owners, and forcibly ends any tenure reaching MAXHOLD cycles.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : req in; gnt/sel/busy/expire out (all outputs registered)
// MAXHOLD : maximum tenure in cycles, 1..255.
module bus_arb4 #(
    parameter int unsigned MAXHOLD = 8
) (
    input  logic        clk,
    input  logic        reset,
    bus_arb4_if.master  bus
);
    import bus_arb_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXHOLD - 1);

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             expire_q, expire_d;

    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic [NREQ-1:0]  gnt;

    // One picker serves both IDLE and TURN; ptr_q already reflects the last release.
    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        expire_d = 1'b0;

        unique case (state_q)
            S_IDLE, S_TURN: begin
                if (pick_valid) begin
                    state_d = S_OWN;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OWN: begin
                // A dropped request wins over expiry: a voluntary release never flags expire.
                if (!bus.req[sel_q]) begin
                    state_d = S_TURN;
                    ptr_d   = sel_q + 2'd1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d  = S_TURN;
                    ptr_d    = sel_q + 2'd1;
                    expire_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_OWN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            expire_q <= expire_d;
        end
    end

    dec24 u_dec (
        .sel (sel_q),
        .en  (state_q == S_OWN),
        .y   (gnt)
    );

    assign bus.gnt    = gnt;
    assign bus.sel    = sel_q;
    assign bus.busy   = busy_q;
    assign bus.expire = expire_q;

endmodule
